// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: store-type encodings used by the store buffer and
// the store byte-enable generator, plus common word/byte-enable types.
package store_buffer_pkg;

    localparam int ST_SEL_W = 3;
    localparam int LANES    = 4;

    typedef enum logic [ST_SEL_W-1:0] {
        ST_SB  = 3'd0,
        ST_SH  = 3'd1,
        ST_SW  = 3'd2,
        ST_SWL = 3'd3,
        ST_SWR = 3'd4
    } store_sel_e;

    typedef logic [31:0]      word_t;
    typedef logic [LANES-1:0] byte_en_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-side and memory-side bus of the store buffer.
interface store_buffer_if #(
    parameter int AW = 32
);
    import store_buffer_pkg::*;

    // Both channels are valid/ready: a transfer happens on a cycle where the source
    // asserts valid (st_valid / mem_req) and the sink asserts ready (st_ready / mem_ack);
    // the source holds its payload stable until that cycle.
    logic                st_valid;
    logic                st_ready;
    logic [AW-1:0]       st_addr;
    logic [ST_SEL_W-1:0] st_sel;
    byte_en_t            st_b_w_en;
    word_t               st_data;

    logic                mem_req;
    logic                mem_ack;
    logic [AW-1:0]       mem_addr;
    word_t               mem_wdata;
    byte_en_t            mem_b_w_en;

    modport master (
        output st_valid, st_addr, st_sel, st_b_w_en, st_data,
        input  st_ready,
        input  mem_req, mem_addr, mem_wdata, mem_b_w_en,
        output mem_ack
    );

    modport slave (
        input  st_valid, st_addr, st_sel, st_b_w_en, st_data,
        output st_ready,
        output mem_req, mem_addr, mem_wdata, mem_b_w_en,
        input  mem_ack
    );

endinterface

// File: rtl/store_buffer_data_align.sv
// Moves raw rt data onto big-endian byte lanes according to store type and byte offset.
module store_data_align
    import store_buffer_pkg::*;
(
    input  logic [ST_SEL_W-1:0] sel,
    input  logic [1:0]          byte_off,
    input  word_t               data,
    output word_t               lane_data
);

    always_comb begin
        lane_data = data;
        case (store_sel_e'(sel))
            ST_SB:   lane_data = {4{data[7:0]}};
            ST_SH:   lane_data = {2{data[15:0]}};
            ST_SW:   lane_data = data;
            // Unaligned halves: byte offset 0 is the most significant lane.
            ST_SWL:  lane_data = data >> {byte_off, 3'b000};
            ST_SWR:  lane_data = data << {2'd3 - byte_off, 3'b000};
            default: lane_data = data;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store write buffer: aligns stores, queues them in a DEPTH-entry FIFO, drains them to
// data memory over req/ack and flags loads that hit a pending store word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    store_buffer_if.slave              bus,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WAW = AW - 2;

    logic [WAW-1:0]   ent_addr [DEPTH];
    word_t            ent_data [DEPTH];
    byte_en_t         ent_be   [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    word_t lane_data;
    logic  full;
    logic  push;
    logic  pop;
    logic  unused_ld_off;

    store_data_align u_align (
        .sel       (bus.st_sel),
        .byte_off  (bus.st_addr[1:0]),
        .data      (bus.st_data),
        .lane_data (lane_data)
    );

    // Ready looks only at the registered count, so a full buffer never takes a store
    // in the same cycle that the head is acknowledged.
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign bus.st_ready = rst_n && !full;

    // A store with no byte enables is handshaken but never occupies a slot.
    assign push = bus.st_valid && bus.st_ready && (bus.st_b_w_en != '0);
    assign pop  = bus.mem_req && bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= bus.st_addr[AW-1:2];
            ent_data[wr_ptr] <= lane_data;
            ent_be[wr_ptr]   <= bus.st_b_w_en;
        end
    end

    assign bus.mem_req    = !empty;
    assign bus.mem_addr   = empty ? '0 : {ent_addr[rd_ptr], 2'b00};
    assign bus.mem_wdata  = empty ? '0 : ent_data[rd_ptr];
    assign bus.mem_b_w_en = empty ? '0 : ent_be[rd_ptr];

    // Word-granular hit over registered entries; the store being enqueued is not visible.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == ld_addr[AW-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign unused_ld_off = ^ld_addr[1:0];
    assign count         = cnt;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          empty;
    logic [2:0]    count;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model entry: {word address with [1:0]=0, lane data, byte enables}
    logic [67:0] exp_q[$];

    store_buffer_if #(.AW(AW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .ld_addr (ld_addr),
        .ld_hit  (ld_hit),
        .empty   (empty),
        .count   (count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_align(input logic [2:0] sel, input logic [1:0] off,
                                                input logic [31:0] d);
        case (sel)
            3'd0:    return {24'h0, d[7:0]} * 32'h0101_0101;
            3'd1:    return {16'h0, d[15:0]} * 32'h0001_0001;
            3'd3:    return d >> (8 * int'(off));
            3'd4:    return d << (8 * (3 - int'(off)));
            default: return d;
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        foreach (exp_q[i]) begin
            if (exp_q[i][67:38] == a[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_can_accept();
        return exp_q.size() < DEPTH;
    endfunction

    // One clock: the model decides the handshakes from its own occupancy.
    task automatic step();
        bit          do_push;
        bit          do_pop;
        logic [67:0] ent;
        do_push = bus.st_valid && model_can_accept() && (bus.st_b_w_en != 4'b0);
        do_pop  = bus.mem_ack && (exp_q.size() > 0);
        ent     = {bus.st_addr & ~32'h3, model_align(bus.st_sel, bus.st_addr[1:0], bus.st_data),
                   bus.st_b_w_en};
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ent);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_store(input logic [31:0] addr, input logic [2:0] sel,
                               input logic [3:0] be, input logic [31:0] data);
        bus.st_valid  = 1'b1;
        bus.st_addr   = addr;
        bus.st_sel    = sel;
        bus.st_b_w_en = be;
        bus.st_data   = data;
    endtask

    task automatic idle_store();
        bus.st_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_sel    = '0;
        bus.st_b_w_en = '0;
        bus.st_data   = '0;
        bus.mem_ack   = 1'b0;
        ld_addr       = '0;
        repeat (2) @(posedge clk);
        #3;
        checks_total++;
        if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req);
        else checks_passed++;
        checks_total++;
        if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty);
        else checks_passed++;
        checks_total++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else checks_passed++;
        checks_total++;
        if (bus.st_ready !== 1'b0) $display("FAIL reset_st_ready: got %b expected 0", bus.st_ready);
        else checks_passed++;
        checks_total++;
        if (ld_hit !== 1'b0) $display("FAIL reset_ld_hit: got %b expected 0", ld_hit);
        else checks_passed++;
        checks_total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_b_w_en} !== 68'h0)
            $display("FAIL reset_mem_fields: got %h/%h/%h expected 0", bus.mem_addr, bus.mem_wdata,
                     bus.mem_b_w_en);
        else checks_passed++;
        rst_n = 1'b1;
        #1;
        checks_total++;
        if (bus.st_ready !== 1'b1) $display("FAIL release_st_ready: got %b expected 1", bus.st_ready);
        else checks_passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_store();
        drive_store(32'h100, ST_SW, 4'b1111, 32'h1122_3344);
        #2;
        checks_total++;
        if (bus.mem_req !== 1'b0) $display("FAIL first_req_early: got %b expected 0", bus.mem_req);
        else checks_passed++;
        step();
        idle_store();
        #2;
        checks_total++;
        if (bus.mem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", bus.mem_req);
        else checks_passed++;
        checks_total++;
        if (bus.mem_addr !== 32'h100) $display("FAIL first_addr: got %h expected 00000100", bus.mem_addr);
        else checks_passed++;
        checks_total++;
        if (bus.mem_wdata !== 32'h1122_3344)
            $display("FAIL first_wdata: got %h expected 11223344", bus.mem_wdata);
        else checks_passed++;
        checks_total++;
        if (bus.mem_b_w_en !== 4'b1111) $display("FAIL first_be: got %b expected 1111", bus.mem_b_w_en);
        else checks_passed++;
        checks_total++;
        if (count !== 3'd1) $display("FAIL first_count: got %0d expected 1", count);
        else checks_passed++;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #2;
        checks_total++;
        if (empty !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL first_drained: got empty=%b req=%b expected empty=1 req=0", empty, bus.mem_req);
        else checks_passed++;
    endtask

    task automatic test_align();
        logic [31:0] a   [4] = '{32'h102, 32'h106, 32'h201, 32'h201};
        logic [2:0]  s   [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
        logic [31:0] d   [4] = '{32'h0000_00AB, 32'h0000_BEEF, 32'hAABB_CCDD, 32'hAABB_CCDD};
        logic [3:0]  b   [4] = '{4'b0010, 4'b0011, 4'b0111, 4'b1100};
        logic [31:0] ea  [4] = '{32'h100, 32'h104, 32'h200, 32'h200};
        logic [31:0] ew  [4] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'h00AA_BBCC, 32'hCCDD_0000};
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(a[i], s[i], b[i], d[i]);
            step();
        end
        idle_store();
        for (int i = 0; i < 4; i++) begin
            #2;
            checks_total++;
            if (bus.mem_addr !== ea[i] || bus.mem_wdata !== ew[i] || bus.mem_b_w_en !== b[i])
                $display("FAIL align_%0d: got %h/%h/%b expected %h/%h/%b", i, bus.mem_addr,
                         bus.mem_wdata, bus.mem_b_w_en, ea[i], ew[i], b[i]);
            else checks_passed++;
            bus.mem_ack = 1'b1;
            step();
        end
        bus.mem_ack = 1'b0;
        #2;
        checks_total++;
        if (empty !== 1'b1) $display("FAIL align_empty: got %b expected 1", empty);
        else checks_passed++;
    endtask

    task automatic test_full();
        logic [31:0] data [5];
        bit          accepted;
        for (int i = 0; i < 5; i++) data[i] = $urandom;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_store(32'h400 + 32'(4 * (i < 5 ? i : 4)), ST_SW, 4'b1111, data[i < 5 ? i : 4]);
            #2;
            checks_total++;
            if (bus.st_ready !== (i < 4))
                $display("FAIL full_ready_%0d: got %b expected %b", i, bus.st_ready, (i < 4));
            else checks_passed++;
            checks_total++;
            if (count !== 3'((i < 4) ? i : 4))
                $display("FAIL full_count_%0d: got %0d expected %0d", i, count, (i < 4) ? i : 4);
            else checks_passed++;
            if (i > 0) begin
                checks_total++;
                if (bus.mem_wdata !== data[0] || bus.mem_addr !== 32'h400)
                    $display("FAIL full_head_stable_%0d: got %h/%h expected 00000400/%h", i,
                             bus.mem_addr, bus.mem_wdata, data[0]);
                else checks_passed++;
            end
            step();
        end
        // 5th store is still held; ack every cycle and drain in order.
        bus.mem_ack = 1'b1;
        for (int n = 0; n < 12 && (exp_q.size() > 0 || bus.st_valid); n++) begin
            #2;
            checks_total++;
            if (bus.st_ready !== model_can_accept())
                $display("FAIL drain_ready_%0d: got %b expected %b", n, bus.st_ready, model_can_accept());
            else checks_passed++;
            if (exp_q.size() > 0) begin
                checks_total++;
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_b_w_en} !== exp_q[0])
                    $display("FAIL drain_head_%0d: got %h/%h/%b expected %h/%h/%b", n, bus.mem_addr,
                             bus.mem_wdata, bus.mem_b_w_en, exp_q[0][67:36], exp_q[0][35:4],
                             exp_q[0][3:0]);
                else checks_passed++;
            end
            accepted = bus.st_valid && model_can_accept();
            step();
            if (accepted) idle_store();
        end
        bus.mem_ack = 1'b0;
        #2;
        checks_total++;
        if (empty !== 1'b1 || count !== 3'd0 || bus.st_valid !== 1'b0)
            $display("FAIL full_drained: got empty=%b count=%0d expected empty=1 count=0", empty, count);
        else checks_passed++;
    endtask

    task automatic test_ld_hit();
        ld_addr = 32'h302;
        drive_store(32'h300, ST_SW, 4'b1111, $urandom);
        #2;
        checks_total++;
        if (ld_hit !== 1'b0) $display("FAIL hit_same_cycle: got %b expected 0", ld_hit);
        else checks_passed++;
        step();
        idle_store();
        #2;
        checks_total++;
        if (ld_hit !== 1'b1) $display("FAIL hit_pending: got %b expected 1", ld_hit);
        else checks_passed++;
        ld_addr = 32'h304;
        #1;
        checks_total++;
        if (ld_hit !== 1'b0) $display("FAIL hit_other_word: got %b expected 0", ld_hit);
        else checks_passed++;
        ld_addr = 32'h302;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #2;
        checks_total++;
        if (ld_hit !== 1'b0) $display("FAIL hit_after_ack: got %b expected 0", ld_hit);
        else checks_passed++;
        drive_store(32'h500, ST_SW, 4'b0000, $urandom);
        #2;
        checks_total++;
        if (bus.st_ready !== 1'b1) $display("FAIL zero_be_ready: got %b expected 1", bus.st_ready);
        else checks_passed++;
        step();
        idle_store();
        #2;
        checks_total++;
        if (count !== 3'd0 || bus.mem_req !== 1'b0)
            $display("FAIL zero_be_dropped: got count=%0d req=%b expected 0/0", count, bus.mem_req);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h600 + 32'(4 * i), ST_SW, 4'b1111, $urandom);
            step();
        end
        idle_store();
        #2;
        checks_total++;
        if (bus.mem_req !== 1'b1 || count !== 3'd3)
            $display("FAIL mid_pending: got req=%b count=%0d expected 1/3", bus.mem_req, count);
        else checks_passed++;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if (bus.mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || bus.st_ready !== 1'b0)
            $display("FAIL mid_async_reset: got req=%b count=%0d empty=%b ready=%b expected 0/0/1/0",
                     bus.mem_req, count, empty, bus.st_ready);
        else checks_passed++;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit          accepted;
        logic [31:0] head;
        for (int n = 0; n < 300; n++) begin
            if (!bus.st_valid) begin
                if ($urandom_range(0, 3) != 0)
                    drive_store(32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                                3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), $urandom);
            end
            bus.mem_ack = 1'($urandom_range(0, 1));
            ld_addr     = 32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            #2;
            checks_total++;
            if (bus.st_ready !== model_can_accept())
                $display("FAIL rnd_ready_%0d: got %b expected %b", n, bus.st_ready, model_can_accept());
            else checks_passed++;
            checks_total++;
            if (count !== 3'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
                bus.mem_req !== (exp_q.size() > 0))
                $display("FAIL rnd_occupancy_%0d: got count=%0d empty=%b req=%b expected count=%0d",
                         n, count, empty, bus.mem_req, exp_q.size());
            else checks_passed++;
            checks_total++;
            if (exp_q.size() > 0) begin
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_b_w_en} !== exp_q[0])
                    $display("FAIL rnd_head_%0d: got %h/%h/%b expected %h/%h/%b", n, bus.mem_addr,
                             bus.mem_wdata, bus.mem_b_w_en, exp_q[0][67:36], exp_q[0][35:4],
                             exp_q[0][3:0]);
                else checks_passed++;
            end else begin
                head = bus.mem_wdata;
                if (bus.mem_addr !== 32'h0 || head !== 32'h0 || bus.mem_b_w_en !== 4'h0)
                    $display("FAIL rnd_idle_fields_%0d: got %h/%h/%b expected 0", n, bus.mem_addr,
                             head, bus.mem_b_w_en);
                else checks_passed++;
            end
            checks_total++;
            if (ld_hit !== model_hit(ld_addr))
                $display("FAIL rnd_ld_hit_%0d: got %b expected %b", n, ld_hit, model_hit(ld_addr));
            else checks_passed++;
            accepted = bus.st_valid && model_can_accept();
            step();
            if (accepted) idle_store();
        end
        idle_store();
        bus.mem_ack = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_store();
        test_align();
        test_full();
        test_ld_hit();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
